bcd_xs3_seq_conv: RTL and testbench

//   Multi-digit, digit-serial BCD <-> Excess-3 code converter with valid/ready handshake.
//   - Converts one NDIGITS-wide packed word per transaction, one digit per clock, LSD first.
//   - Direction is selected per transaction.
//   - Flags invalid digits and keeps a saturating error count.
//   - Sits between the BCD datapath (counters, displays) and Excess-3 arithmetic/consumers.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/xs3_digit_conv.sv | 24 ++
 rtl/bcd_xs3_seq_conv.sv | 106 ++++++++++
 tb/tb_bcd_xs3_seq_conv.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD <-> Excess-3 converter:
// FSM encoding, code-range limits and direction selectors.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] XS3_OFFSET    = 4'd3;
  localparam logic [3:0] BCD_MAX       = 4'd9;
  localparam logic [3:0] XS3_MIN       = 4'd3;
  localparam logic [3:0] XS3_MAX       = 4'd12;
  localparam logic [3:0] INVALID_DIGIT = 4'hF;

  localparam logic MODE_BCD2XS3 = 1'b0;
  localparam logic MODE_XS32BCD = 1'b1;

endpackage

// File: rtl/xs3_digit_conv.sv
// Combinational single-digit converter: BCD->XS3 (mode 0) or XS3->BCD (mode 1).
// Out-of-range digits produce INVALID_DIGIT and raise invalid.
module xs3_digit_conv
  import bcd_pkg::*;
(
  input  logic       mode,
  input  logic [3:0] digit,
  output logic [3:0] out,
  output logic       invalid
);

  always_comb begin
    out     = INVALID_DIGIT;
    invalid = 1'b0;
    if (mode == MODE_BCD2XS3) begin
      if (digit <= BCD_MAX) out = digit + XS3_OFFSET;
      else                  invalid = 1'b1;
    end else begin
      if (digit >= XS3_MIN && digit <= XS3_MAX) out = digit - XS3_OFFSET;
      else                                      invalid = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_xs3_seq_conv.sv
// Digit-serial BCD <-> Excess-3 word converter, one digit per clock, LSD first.
// Handshake: a beat transfers on a rising edge where valid and ready are both high;
// the source holds valid and data stable until then, and ready never depends on valid.
module bcd_xs3_seq_conv
  import bcd_pkg::*;
#(
  parameter int NDIGITS   = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [4*NDIGITS-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_data,
  output logic [NDIGITS-1:0]     err_mask,
  output logic                   err,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output state_e                 state_dbg
);

  localparam int W     = 4 * NDIGITS;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIGITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     data_q;
  logic             mode_q;
  logic [3:0]       digit_in, digit_out;
  logic             digit_inv;
  logic             accept;
  logic             release_out;

  assign accept      = in_valid && in_ready;
  assign release_out = (state_q == DONE) && out_ready;
  assign digit_in    = data_q[{cnt_q, 2'b00} +: 4];

  xs3_digit_conv u_digit (
    .mode    (mode_q),
    .digit   (digit_in),
    .out     (digit_out),
    .invalid (digit_inv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready is forced low while rst is asserted, even though state is already IDLE.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    err       = out_valid && (|err_mask);
    state_dbg = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      data_q   <= '0;
      mode_q   <= MODE_BCD2XS3;
      out_data <= '0;
      err_mask <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          data_q   <= in_data;
          mode_q   <= in_mode;
          err_mask <= '0;
          cnt_q    <= '0;
        end
        CONV: begin
          out_data[{cnt_q, 2'b00} +: 4] <= digit_out;
          err_mask[cnt_q]               <= digit_inv;
          cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Counts erroneous words as they leave; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (release_out && (|err_mask) && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_xs3_seq_conv.sv
// Directed bench for bcd_xs3_seq_conv: conversion, latency, error flags,
// backpressure, mid-transaction reset and counter saturation (second instance).
module tb_bcd_xs3_seq_conv;
  import bcd_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (NDIGITS=4, ERR_CNT_W=8)
  logic        in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, err;
  logic [15:0] out_data;
  logic [3:0]  err_mask;
  logic [7:0]  err_cnt;
  state_e      state_dbg;

  bcd_xs3_seq_conv #(.NDIGITS(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_mask(err_mask), .err(err), .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  // saturation instance (ERR_CNT_W=2)
  logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [15:0] in_data2 = '0;
  logic        in_ready2, out_valid2, err2;
  logic [15:0] out_data2;
  logic [3:0]  err_mask2;
  logic [1:0]  err_cnt2;
  state_e      state_dbg2;

  bcd_xs3_seq_conv #(.NDIGITS(4), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_mode(1'b0), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .err_mask(err_mask2), .err(err2), .err_cnt(err_cnt2), .state_dbg(state_dbg2)
  );

  int n_asserts = 0;
  int n_fails   = 0;
  logic [15:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a word until accepted, then scrambles the inputs to prove they were latched.
  task automatic send_word(input logic mode, input logic [15:0] data, input logic [15:0] exp_data);
    int guard;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("accept_timeout", 32'(guard < 50), 32'd1);
    tick();
    in_valid = 1'b0;
    in_mode  = ~mode;
    in_data  = 16'($urandom_range(0, 16'hFFFF));
    exp_q.push_back(exp_data);
  endtask

  // Counts clocks from the accept edge until out_valid; must equal NDIGITS.
  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd4);
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_mask, input logic [7:0] exp_cnt);
    logic [15:0] exp_data;
    exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
    chk({tag, "_mask"}, 32'(err_mask), 32'(exp_mask));
    chk({tag, "_err"},  32'(err), 32'(exp_mask != 4'd0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
  endtask

  logic [15:0] held_data;
  logic [1:0]  sat_exp [5];

  initial begin
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_err_mask", 32'(err_mask), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_state", 32'(state_dbg), 32'(IDLE));

    // 1: BCD -> XS3
    send_word(MODE_BCD2XS3, 16'h1234, 16'h4567);
    chk("s1_state_conv", 32'(state_dbg), 32'(CONV));
    wait_out("s1");
    check_out("s1", 4'b0000, 8'd0);

    // 2: XS3 -> BCD, clean and with invalid digits
    send_word(MODE_XS32BCD, 16'h4567, 16'h1234);
    wait_out("s2a");
    check_out("s2a", 4'b0000, 8'd0);
    send_word(MODE_XS32BCD, 16'h0C3F, 16'hF90F);
    wait_out("s2b");
    check_out("s2b", 4'b1001, 8'd1);

    // 3: invalid BCD digit
    send_word(MODE_BCD2XS3, 16'h9A05, 16'hCF38);
    wait_out("s3");
    check_out("s3", 4'b0100, 8'd2);

    // 4: backpressure with a second word waiting
    send_word(MODE_BCD2XS3, 16'h0987, 16'h3CBA);
    wait_out("s4a");
    held_data = out_data;
    in_valid  = 1'b1;
    in_mode   = MODE_BCD2XS3;
    in_data   = 16'h0246;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s4_hold_data", 32'(out_data), 32'(held_data));
      chk("s4_hold_in_ready", 32'(in_ready), 32'd0);
      chk("s4_hold_valid", 32'(out_valid), 32'd1);
    end
    check_out("s4a", 4'b0000, 8'd2);
    chk("s4_idle_after_hs", 32'(state_dbg), 32'(IDLE));
    chk("s4_ready_after_hs", 32'(in_ready), 32'd1);
    send_word(MODE_BCD2XS3, 16'h0246, 16'h3579);
    chk("s4_second_conv", 32'(state_dbg), 32'(CONV));
    wait_out("s4b");
    check_out("s4b", 4'b0000, 8'd2);

    // 5: reset during the second CONV clock
    send_word(MODE_BCD2XS3, 16'h5555, 16'h8888);
    void'(exp_q.pop_back());
    tick();
    rst = 1'b1;
    #1;
    chk("s5_rst_valid", 32'(out_valid), 32'd0);
    chk("s5_rst_data", 32'(out_data), 32'd0);
    chk("s5_rst_in_ready", 32'(in_ready), 32'd0);
    chk("s5_rst_err_cnt", 32'(err_cnt), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("s5_release_ready", 32'(in_ready), 32'd1);
    send_word(MODE_BCD2XS3, 16'h0000, 16'h3333);
    wait_out("s5");
    check_out("s5", 4'b0000, 8'd0);

    // 6: saturating counter on the 2-bit instance
    for (int w = 0; w < 5; w++) begin
      int guard;
      in_valid2 = 1'b1;
      in_data2  = 16'hFFFF;
      guard = 0;
      while (!in_ready2 && guard < 50) begin tick(); guard++; end
      tick();
      in_valid2 = 1'b0;
      guard = 0;
      while (!out_valid2 && guard < 20) begin tick(); guard++; end
      chk("s6_latency", guard, 32'd4);
      chk("s6_data", 32'(out_data2), 32'h0000FFFF);
      chk("s6_err", 32'(err2), 32'd1);
      out_ready2 = 1'b1;
      tick();
      out_ready2 = 1'b0;
      chk("s6_err_cnt", 32'(err_cnt2), 32'(sat_exp[w]));
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
